ula_exec: RTL and testbench



---
 rtl/ula_exec_if.sv | 27 ++
 rtl/ula_exec.sv | 165 ++++++++++++++++
 tb/tb_ula_exec.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ula_exec_if.sv
// Request/response bundle between the EX-stage control FSM (master) and ula_exec (slave).
interface ula_exec_if #(
  parameter int WIDTH = 32
);
  localparam int SW = $clog2(WIDTH);

  logic             start;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             invalid;
  logic             busy;
  logic             done;

  modport master (
    output start, ALUControl, A, B, shamt,
    input  result, zero, invalid, busy, done
  );

  modport slave (
    input  start, ALUControl, A, B, shamt,
    output result, zero, invalid, busy, done
  );
endinterface

// File: rtl/ula_exec.sv
// Multi-cycle ULA execution unit: single-cycle logic/arithmetic, iterative 1-bit/cycle shifts.
// Define ULA_FAST_SHIFT_EN to replace the iterative shifter with a combinational barrel shifter.
module ula_exec #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  ula_exec_if.slave bus
);
  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0] calc_result;
  logic             calc_zero;
  logic             calc_invalid;
  logic             shift_op;
  logic             shift_left;
  logic             shift_arith;
  logic [SW-1:0]    shift_amt;

  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;
  logic             invalid_reg;
  logic             done_reg;

  always_comb begin
    calc_result  = '0;
    calc_invalid = 1'b0;
    shift_op     = 1'b0;
    shift_left   = 1'b0;
    shift_arith  = 1'b0;
    shift_amt    = bus.shamt;
    case (bus.ALUControl)
      4'b0000: calc_result = bus.A & bus.B;
      4'b0001: calc_result = bus.A | bus.B;
      4'b0010: calc_result = bus.A + bus.B;
      4'b0110: calc_result = bus.A - bus.B;
      4'b1011: calc_result = bus.A ^ bus.B;
      4'b1100: calc_result = ~(bus.A | bus.B);
      4'b0111: calc_result = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      4'b1111: calc_result = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      4'b1000: calc_result = bus.A - bus.B;
      4'b0011: begin shift_op = 1'b1; shift_left = 1'b1; shift_amt = bus.A[SW-1:0]; end
      4'b0100: begin shift_op = 1'b1; shift_amt = bus.A[SW-1:0]; end
      4'b0101: begin shift_op = 1'b1; shift_arith = 1'b1; shift_amt = bus.A[SW-1:0]; end
      4'b1001: begin shift_op = 1'b1; shift_left = 1'b1; end
      4'b1010: shift_op = 1'b1;
      4'b1101: begin shift_op = 1'b1; shift_arith = 1'b1; end
      default: calc_invalid = 1'b1;
    endcase
`ifdef ULA_FAST_SHIFT_EN
    if (shift_op) begin
      if (shift_left)
        calc_result = bus.B << shift_amt;
      else if (shift_arith)
        calc_result = $unsigned($signed(bus.B) >>> shift_amt);
      else
        calc_result = bus.B >> shift_amt;
    end
`else
    // Only zero-amount shifts complete here; longer ones go through the SHIFT state.
    if (shift_op)
      calc_result = bus.B;
`endif
    // BNE reports inequality on zero so branch logic always tests the same flag.
    if (calc_invalid)
      calc_zero = 1'b1;
    else if (bus.ALUControl == 4'b1000)
      calc_zero = (bus.A != bus.B);
    else
      calc_zero = (calc_result == '0);
  end

`ifdef ULA_FAST_SHIFT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      result_reg  <= '0;
      zero_reg    <= 1'b0;
      invalid_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (bus.start) begin
        result_reg  <= calc_result;
        zero_reg    <= calc_zero;
        invalid_reg <= calc_invalid;
        done_reg    <= 1'b1;
      end
    end
  end

  assign bus.busy = 1'b0;
`else
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;
  logic [SW-1:0]    count;
  logic             dir_left;
  logic             arith_shift;
  logic             busy_reg;

  always_comb begin
    if (dir_left)
      work_next = {work[WIDTH-2:0], 1'b0};
    else
      work_next = {arith_shift & work[WIDTH-1], work[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      work        <= '0;
      count       <= '0;
      dir_left    <= 1'b0;
      arith_shift <= 1'b0;
      result_reg  <= '0;
      zero_reg    <= 1'b0;
      invalid_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            invalid_reg <= calc_invalid;
            if (shift_op && (shift_amt != '0)) begin
              work        <= bus.B;
              count       <= shift_amt;
              dir_left    <= shift_left;
              arith_shift <= shift_arith;
              busy_reg    <= 1'b1;
              state       <= SHIFT;
            end else begin
              result_reg <= calc_result;
              zero_reg   <= calc_zero;
              done_reg   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work  <= work_next;
          count <= count - 1'b1;
          if (count == SW'(1)) begin
            result_reg <= work_next;
            zero_reg   <= (work_next == '0);
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_reg;
`endif

  assign bus.result  = result_reg;
  assign bus.zero    = zero_reg;
  assign bus.invalid = invalid_reg;
  assign bus.done    = done_reg;
endmodule

// File: tb/tb_ula_exec.sv
// Scoreboard bench for ula_exec: expected responses are queued at issue and checked on each done pulse.
module tb_ula_exec;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_run = 0;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        inv;
    int          due;
    int          nbusy;
  } exp_t;

  exp_t sb[$];

  ula_exec_if #(.WIDTH(32)) bus ();

  ula_exec #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model written from the operation rules with plain integer arithmetic.
  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] r, output logic z,
                                output logic inv, output int n);
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    longint sa = longint'($signed(a));
    longint sbv = longint'($signed(b));
    longint p = 1;
    r = 32'd0;
    inv = 1'b0;
    n = 0;
    case (c)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = 32'(ua + ub);
      4'd6:  r = 32'(ua - ub);
      4'd11: r = a ^ b;
      4'd12: r = ~(a | b);
      4'd7:  r = (sa < sbv) ? 32'd1 : 32'd0;
      4'd15: r = (ua < ub) ? 32'd1 : 32'd0;
      4'd8:  r = 32'(ua - ub);
      4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd13: begin
        n = (c == 4'd3 || c == 4'd4 || c == 4'd5) ? int'(a[4:0]) : int'(sh);
        repeat (n) p = p * 2;
        if (c == 4'd3 || c == 4'd9)
          r = 32'(ub * p);
        else if (c == 4'd4 || c == 4'd10)
          r = 32'(ub / p);
        else if (sbv >= 0)
          r = 32'(sbv / p);
        else
          r = 32'(-(((-sbv) + p - 1) / p));
      end
      default: inv = 1'b1;
    endcase
    if (inv)
      z = 1'b1;
    else if (c == 4'd8)
      z = (a != b);
    else
      z = (r == 32'd0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] sh);
    int   guard = 0;
    exp_t e;
    int   n;
    while (bus.busy === 1'b1 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL busy_timeout actual=busy expected=idle within 100 cycles");
    end
    bus.start      = 1'b1;
    bus.ALUControl = c;
    bus.A          = a;
    bus.B          = b;
    bus.shamt      = sh;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    bus.shamt = 5'($urandom);
    model(c, a, b, sh, e.r, e.z, e.inv, n);
`ifdef ULA_FAST_SHIFT_EN
    n = 0;
`endif
    e.nbusy = n;
    e.due   = edge_cnt + n;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_run = 0;
    end else if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL spurious_done actual=done expected=no done at edge %0d", edge_cnt);
      end else begin
        e = sb.pop_front();
        checkOutput("result", bus.result, e.r);
        checkOutput("zero", 32'(bus.zero), 32'(e.z));
        checkOutput("invalid", 32'(bus.invalid), 32'(e.inv));
        checkOutput("latency_edge", 32'(edge_cnt), 32'(e.due));
        checkOutput("busy_cycles", 32'(busy_run), 32'(e.nbusy));
      end
      busy_run = 0;
    end else if (bus.busy === 1'b1) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  initial begin
    int guard;
    bus.start      = 1'b0;
    bus.ALUControl = 4'd0;
    bus.A          = 32'd0;
    bus.B          = 32'd0;
    bus.shamt      = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_result", bus.result, 32'd0);
    checkOutput("reset_zero", 32'(bus.zero), 32'd0);
    checkOutput("reset_invalid", 32'(bus.invalid), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    reset = 1'b0;

    $display("[TB] directed arithmetic and shifts");
    applyStimulus(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd0);
    applyStimulus(4'b0110, 32'd5, 32'd7, 5'd0);
    applyStimulus(4'b1101, 32'd0, 32'h8000_0000, 5'd4);
    applyStimulus(4'b0100, 32'd4, 32'h8000_0000, 5'd0);
    applyStimulus(4'b1001, 32'd0, 32'h0000_1234, 5'd0);
    applyStimulus(4'b1010, 32'd0, 32'hDEAD_BEEF, 5'd10);
    if (bus.busy === 1'b1) begin
      bus.start      = 1'b1;
      bus.ALUControl = 4'b0010;
      bus.A          = 32'd1;
      bus.B          = 32'd1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    applyStimulus(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0);
    applyStimulus(4'b1111, 32'hFFFF_FFFF, 32'd1, 5'd0);
    applyStimulus(4'b1000, 32'd9, 32'd9, 5'd0);
    applyStimulus(4'b1000, 32'd9, 32'd3, 5'd0);
    applyStimulus(4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
    applyStimulus(4'b0000, 32'h0000_00F0, 32'h0000_003C, 5'd0);
    applyStimulus(4'b0011, 32'd31, 32'h0000_0001, 5'd0);

    $display("[TB] reset during shift");
    applyStimulus(4'b1010, 32'd0, 32'h8000_0000, 5'd20);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    reset          = 1'b1;
    bus.start      = 1'b1;
    bus.ALUControl = 4'b0010;
    bus.A          = 32'd3;
    bus.B          = 32'd4;
    sb.delete();
    @(posedge clk);
    #1;
    checkOutput("midreset_result", bus.result, 32'd0);
    checkOutput("midreset_zero", 32'(bus.zero), 32'd0);
    checkOutput("midreset_invalid", 32'(bus.invalid), 32'd0);
    checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
    checkOutput("midreset_done", 32'(bus.done), 32'd0);
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
    end

    $display("[TB] random operations");
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 2) == 0) a = a & 32'h0000_001F;
      applyStimulus(4'($urandom_range(0, 15)), a, b, 5'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("pending_responses", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
